// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for the SDR divided clock. clk_out and clk_en are registered on clk_in.
// Optional macro CLK_DIV_SYNC_EN adds sync_in, which forces a period restart in RUN/PEND.
module clk_div_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             clk_en,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             cfg_err_q, cfg_err_d;

  logic             take, sync_hit, end_ev, new_pend;
  logic [DIV_W-1:0] pend_src, half;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      clk_en_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      clk_en_q   <= clk_en_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;

    take      = cfg_valid & cfg_ready & (cfg_div >= DIV_W'(2));
    cfg_err_d = cfg_valid & cfg_ready & (cfg_div <  DIV_W'(2));
`ifdef CLK_DIV_SYNC_EN
    sync_hit  = sync_in & ((state_q == RUN) | (state_q == PEND));
`else
    sync_hit  = 1'b0;
`endif
    end_ev    = (cnt_q == cur_div_q - DIV_W'(1)) | sync_hit;
    new_pend  = pend_vld_q | take;
    pend_src  = pend_vld_q ? pend_div_q : cfg_div;

    if (state_q == IDLE) begin
      if (take) cur_div_d = cfg_div;
      if (en) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (end_ev) begin
      // Period boundary: the only point where a new ratio may take effect.
      cnt_d      = '0;
      pend_vld_d = 1'b0;
      if (new_pend) cur_div_d = pend_src;
      if (en)                   state_d = RUN;
      else if (state_q == PEND) state_d = STOP;
      else                      state_d = IDLE;
    end else begin
      cnt_d      = cnt_q + DIV_W'(1);
      pend_vld_d = new_pend;
      if (new_pend) pend_div_d = pend_src;
      if (en)                   state_d = new_pend ? PEND : RUN;
      else if (state_q == PEND) state_d = PEND;
      else                      state_d = STOP;
    end

    // Outputs track the upcoming counter value so they line up with cnt_q.
    half      = {1'b0, cur_div_d[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, cur_div_d[0]};
    clk_out_d = (state_d != IDLE) && (cnt_d < half);
    clk_en_d  = (state_d != IDLE) && (cnt_d == '0);
  end

  always_comb begin
    cfg_ready = (state_q == IDLE) || (state_q == RUN);
    busy      = (state_q != IDLE);
    clk_out   = clk_out_q;
    clk_en    = clk_en_q;
    cfg_err   = cfg_err_q;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run/stop and ratio controller for the SDR clock divider path.
- Derives a divided clock and a matching single-cycle enable from clk_in (3.125 MHz reference, 320 ns period).
- Accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries, so clk_out never produces a runt pulse.
- Downstream sample logic stays on clk_in and qualifies with clk_en.

Parameters:
- DIV_W, 16, width of divide ratio and internal counter.
- DEFAULT_DIV, 8, ratio loaded at reset; must be >= 2.

Ports:
- clk_in  input  1  sole clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- cfg_div  input  DIV_W  requested divide ratio.
- cfg_valid  input  1  cfg_div valid.
- cfg_ready  output  1  controller can accept cfg_div.
- clk_out  output  1  registered divided clock.
- clk_en  output  1  one-cycle pulse, coincident with each clk_out rising edge.
- busy  output  1  high while not in IDLE.
- cfg_err  output  1  one-cycle pulse when an illegal ratio is presented.

Behaviour:
- Reset values:
  - all outputs 0, except cfg_ready = 1;
  - state IDLE, cnt = 0, cur_div = DEFAULT_DIV, pend_div = 0.
- States: IDLE, RUN, PEND, STOP.
- IDLE:
  - clk_out = 0.
  - Accepted cfg writes cur_div directly, effective next cycle.
  - en = 1 -> RUN, cnt = 0; clk_out and clk_en are 1 on the next edge (1-cycle latency).
- RUN:
  - cnt increments and wraps from cur_div-1 to 0.
  - clk_out = 1 when cnt < ceil(cur_div/2), else 0.
  - Odd ratios are high for the extra cycle.
  - clk_en = 1 exactly when cnt = 0.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = 1 in IDLE and RUN, 0 in PEND and STOP.
  - cfg_div < 2 -> cfg_err pulses next cycle; the value is discarded and the state is unchanged.
  - A legal value accepted in RUN is latched into pend_div and the state goes to PEND.
- PEND:
  - Counting continues on cur_div.
  - At the wrap cycle (cnt = cur_div-1): cur_div <= pend_div, cnt <= 0, state returns to RUN (or STOP if en = 0).
  - The new period starts cleanly high.
- en = 0 in RUN -> STOP:
  - The current period completes.
  - At wrap, clk_out is held 0, cnt = 0, state goes to IDLE.
  - No clk_en pulse is issued after the stop.
- en reasserted in STOP before wrap: return to RUN, no disturbance to the period.
- Simultaneous accepted cfg and en falling in RUN: pend_div is latched; the ratio is applied at the stop wrap; the state ends in IDLE.
- Reset mid-operation: immediate return to reset values; clk_out drops asynchronously.
- Counter width: DIV_W. cfg_div = 2^DIV_W-1 is legal. No overflow is possible because cnt < cur_div.

Optional Feature:
- Macro: CLK_DIV_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in = 1 in RUN or PEND forces cnt <= 0 on the next edge, which gives clk_out = 1 and clk_en = 1 in that cycle. This phase-aligns multiple dividers.
  - A pending ratio is applied at the sync point.
  - sync_in is ignored in IDLE and STOP.
- Undefined: the port is absent and counting is never interrupted.

Test Plan:
1. Reset with DEFAULT_DIV = 8, then en = 1 -> clk_out is 4 high / 4 low cycles (2560 ns period); clk_en pulses every 8 cycles, the first one cycle after en.
2. In RUN at div 8, write cfg_div = 5 at cnt = 2 -> cfg_ready drops; the current period stays 8 cycles; the next periods are 3 high / 2 low; cfg_ready returns to 1.
3. Write cfg_div = 1, then 0 -> cfg_err pulses once for each; cfg_ready stays high; the ratio is unchanged.
4. Drop en at cnt = 1 of div 8 -> the period completes 8 cycles, clk_out stays 0, busy falls, and there are no further clk_en pulses.
5. Assert rst with clk_out high at cnt = 2 -> clk_out = 0 immediately; after release, the state is IDLE with div 8.
6. With CLK_DIV_SYNC_EN defined, pulse sync_in at cnt = 6 of div 8 -> the next cycle has cnt = 0, clk_out = 1 and clk_en = 1, and regular 8-cycle periods follow.
